// File: rtl/debug_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_run_ctrl
// Brief    : Run/step/reset controller for the RV32 core: stretched reset,
//            free-run or N-cycle step clock enable, IRQ pulse, cycle counter.
//            Define DBG_BREAKPOINT_EN to enable the PC breakpoint halt.
// Revision : 1.0 - initial release
// ============================================================================
module debug_run_ctrl #(
    parameter int RST_STRETCH = 16,
    parameter int STEP_W      = 8,
    parameter int IRQ_LEN     = 4,
    parameter int PC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rst_out,
    input  logic              mode_run,
    input  logic              step_btn,
    input  logic [STEP_W-1:0] step_count,
    input  logic              irq_btn,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_valid,
    output logic              cpu_en,
    output logic              busy,
    output logic              irq_out,
    output logic              bp_hit,
    output logic [31:0]       cycle_cnt
);

    localparam int SW = $clog2(RST_STRETCH + 1);
    localparam int IW = $clog2(IRQ_LEN + 1);

    localparam logic [2:0] HOLD  = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] STEP  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [SW-1:0]     stretch_cnt;
    logic [STEP_W-1:0] remaining;
    logic [IW-1:0]     irq_cnt;
    logic [31:0]       cycle_reg;
    logic              step_q;
    logic              irq_q;
    logic              step_edge;
    logic              irq_edge;
    logic              bp_match;
    logic              stretch_done;
    logic              load_step;
    logic [STEP_W-1:0] step_load;

    // Edge history is deliberately not reset so a level held through reset
    // cannot masquerade as a fresh press.
    always_ff @(posedge clk) begin
        step_q <= step_btn;
        irq_q  <= irq_btn;
    end

    assign step_edge = step_btn & ~step_q;
    assign irq_edge  = irq_btn & ~irq_q;

`ifdef DBG_BREAKPOINT_EN
    assign bp_match = bp_valid && (pc == bp_addr);
    assign bp_hit   = (state == BREAK);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    assign stretch_done = (stretch_cnt == SW'(RST_STRETCH));
    assign step_load    = (step_count == '0) ? STEP_W'(1) : step_count;
    assign load_step    = ((state == IDLE) && !mode_run && step_edge) ||
                          ((state == BREAK) && step_edge);

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    if (stretch_done) state_nxt = mode_run ? RUN : IDLE;
            IDLE:    begin
                if (mode_run)       state_nxt = RUN;
                else if (step_edge) state_nxt = STEP;
            end
            STEP:    if (remaining == STEP_W'(1)) state_nxt = IDLE;
            RUN:     begin
                if (bp_match)       state_nxt = BREAK;
                else if (!mode_run) state_nxt = IDLE;
            end
            BREAK:   begin
                if (step_edge)      state_nxt = STEP;
                else if (!mode_run) state_nxt = IDLE;
            end
            default: state_nxt = HOLD;
        endcase
    end

    // Enable is gated combinationally in RUN so the matching fetch never issues.
    always_comb begin
        cpu_en = 1'b0;
        case (state)
            STEP:    cpu_en = 1'b1;
            RUN:     cpu_en = ~bp_match;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOLD;
            stretch_cnt <= '0;
            remaining   <= '0;
            irq_cnt     <= '0;
            cycle_reg   <= '0;
        end else begin
            state <= state_nxt;

            if ((state == HOLD) && !stretch_done)
                stretch_cnt <= stretch_cnt + SW'(1);

            if (load_step)
                remaining <= step_load;
            else if (state == STEP)
                remaining <= remaining - STEP_W'(1);

            if (state == HOLD)
                irq_cnt <= '0;
            else if (irq_edge)
                irq_cnt <= IW'(IRQ_LEN);
            else if (irq_cnt != '0)
                irq_cnt <= irq_cnt - IW'(1);

            if (state == HOLD)
                cycle_reg <= '0;
            else if (cpu_en)
                cycle_reg <= cycle_reg + 32'd1;
        end
    end

    assign rst_out   = (state == HOLD);
    assign busy      = (state == STEP);
    assign irq_out   = (irq_cnt != '0);
    assign cycle_cnt = cycle_reg;

endmodule
`default_nettype wire

// File: doc/debug_run_ctrl.md
# debug_run_ctrl

Parametrised run/step/reset controller between the board-level button/switch logic and the pipelined RV32 core. Stretches the board reset, generates the core clock enable in free-run or N-cycle single-step mode, produces a fixed-length interrupt pulse from a button, and counts enabled cycles. Optionally halts free-run at a PC breakpoint. Replaces the ad-hoc reset shifter and direct step-button wiring in the board top.

## Interface
Parameters:
- `RST_STRETCH`, 16: cycles `rst_out` stays high after `rst` falls (≥1)
- `STEP_W`, 8: width of `step_count`
- `IRQ_LEN`, 4: `irq_out` pulse length in cycles (≥1)
- `PC_W`, 32: width of `pc` and `bp_addr`

Ports:
- `clk`  in  1  CPU clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rst_out`  out  1  stretched reset to core
- `mode_run`  in  1  1 = free run, 0 = step mode
- `step_btn`  in  1  debounced step level; rising edge = step request
- `step_count`  in  STEP_W  enabled cycles per step request; 0 treated as 1
- `irq_btn`  in  1  debounced interrupt level
- `pc`  in  PC_W  core's current fetch PC
- `bp_addr`  in  PC_W  breakpoint address
- `bp_valid`  in  1  breakpoint armed
- `cpu_en`  out  1  core clock enable
- `busy`  out  1  step sequence in progress
- `irq_out`  out  1  interrupt pulse to core
- `bp_hit`  out  1  halted at breakpoint
- `cycle_cnt`  out  32  number of cycles with `cpu_en`=1 since reset

## Operation
- Edge detectors: `step_q`/`irq_q` sample their inputs every cycle, including during `rst`; a button held through reset produces no edge. Edge = in & ~q.
- FSM states: HOLD, IDLE, STEP, RUN, BREAK.
  - HOLD: `rst_out`=1, `cpu_en`=0, stretch counter runs; on expiry → RUN if `mode_run` else IDLE. Edges ignored.
  - IDLE: `mode_run`=1 → RUN (wins over simultaneous step edge, edge discarded); else step edge → load `remaining` = max(`step_count`,1), → STEP.
  - STEP: `cpu_en`=1, `busy`=1; `remaining` decrements; at `remaining`==1 → IDLE. Further step edges and `mode_run` changes ignored until done. Breakpoint not evaluated.
  - RUN: `cpu_en` = ~`bp_match` (combinational gate), `bp_match` = `bp_valid` & (`pc`==`bp_addr`); `bp_match` → BREAK; else `mode_run`=0 → IDLE.
  - BREAK: `cpu_en`=0, `bp_hit`=1; step edge → STEP (steps past breakpoint); `mode_run`=0 → IDLE; otherwise hold.
- `irq_out`: `irq_btn` edge → high exactly IRQ_LEN cycles; edge during pulse restarts count. Forced 0 in HOLD.
- `cycle_cnt`: +1 each cycle `cpu_en`=1; wraps 0xFFFFFFFF→0; cleared in HOLD.

## Timing
- Reset values (cycle after `rst` sampled high): `rst_out`=1, `cpu_en`=0, `busy`=0, `irq_out`=0, `bp_hit`=0, `cycle_cnt`=0, state HOLD.
- `rst_out` falls exactly RST_STRETCH cycles after the first edge sampling `rst`=0.
- Step: edge sampled at clock edge t → `cpu_en` high cycles t+1 … t+N, low at t+N+1.
- `mode_run` 1→0 in RUN: `cpu_en` low starting the cycle after it is sampled.
- Breakpoint: `cpu_en` drops in the same cycle `pc`==`bp_addr`; the matching instruction is not enabled.
- `rst` mid-operation: aborts any state; HOLD next cycle, pending step and irq pulse discarded.

## Configuration
- `DBG_BREAKPOINT_EN` defined: breakpoint compare, BREAK state and `bp_hit` as above.
- Undefined: ports remain; `pc`, `bp_addr`, `bp_valid` ignored; `bp_match`=0, BREAK unreachable, `bp_hit` tied 0.

## Test plan
- `rst` high 3 cycles, RST_STRETCH=16 → `rst_out` falls exactly 16 cycles after `rst` falls; `cpu_en`=0, `cycle_cnt`=0 throughout.
- Step mode, `step_count`=5, one step pulse → `cpu_en` high 5 consecutive cycles, `busy` high same window, `cycle_cnt`=5; second pulse mid-sequence ignored (`cycle_cnt` stays 5). `step_count`=0 → exactly 1 cycle.
- `mode_run`=1 for 100 cycles then 0 → `cycle_cnt`=100, `cpu_en` low cycle after sampling 0.
- `DBG_BREAKPOINT_EN`, `bp_addr`=0x40, `pc` driven to 0x40 in RUN → `cpu_en` 0 same cycle, `bp_hit`=1; step pulse with `step_count`=1 → one enabled cycle, return to IDLE.
- `irq_btn` pulse, IRQ_LEN=4, retrigger at pulse cycle 2 → `irq_out` high 6 cycles total; `step_btn` held high across reset → no step issued.
- `cycle_cnt` preset near 0xFFFFFFFF (force) in RUN → wraps to 0x00000000 and continues.
